// File: rtl/fc_argmax.sv
// Fully-connected classifier over the flattened layer-2 pooled map: one
// bias+dot product per class, streamed from external ROMs, then arg-max.
module fc_argmax #(
  parameter int IN_LEN  = 784,
  parameter int N_CLASS = 10,
  parameter int DW      = 8,
  parameter int ACC_W   = 25,
  parameter int FA_W    = 10,
  parameter int WA_W    = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [FA_W-1:0]         fmap_addr,
  input  logic signed [DW-1:0]    fmap_data,
  output logic [WA_W-1:0]         w_addr,
  input  logic signed [DW-1:0]    w_data,
  output logic [3:0]              b_addr,
  input  logic signed [DW-1:0]    b_data,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              class_idx,
  output logic signed [ACC_W-1:0] max_score
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CMP, DONE} state_t;

  localparam logic [FA_W-1:0] LAST_I = FA_W'(IN_LEN - 1);
  localparam logic [3:0]      LAST_C = 4'(N_CLASS - 1);
  localparam logic [WA_W-1:0] STEP   = WA_W'(IN_LEN);

  state_t state, state_nx;

  logic [WA_W-1:0]         base;
  logic signed [ACC_W-1:0] acc, best;
  logic [3:0]              best_idx;
  logic                    acc_v, acc_first;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_x, bias_x;
  logic                    better;

  assign prod   = fmap_data * w_data;
  assign prod_x = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign bias_x = {{(ACC_W-DW){b_data[DW-1]}}, b_data};
  // b_addr doubles as the class counter, fmap_addr as the element counter
  assign better = (b_addr == '0) || (acc > best);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   if (fmap_addr == LAST_I) state_nx = DRAIN;
      DRAIN:   state_nx = CMP;
      CMP:     state_nx = (b_addr == LAST_C) ? DONE : ISSUE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fmap_addr <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      base      <= '0;
      acc       <= '0;
      best      <= '0;
      best_idx  <= '0;
      acc_v     <= 1'b0;
      acc_first <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_idx <= '0;
      max_score <= '0;
    end else begin
      // ROM data lags the address by one cycle; tag it with its element slot
      acc_v     <= (state == ISSUE);
      acc_first <= (state == ISSUE) && (fmap_addr == '0);
      if (acc_v) acc <= acc_first ? (bias_x + prod_x) : (acc + prod_x);

      case (state)
        IDLE: if (start) busy <= 1'b1;
        ISSUE: begin
          if (fmap_addr != LAST_I) begin
            fmap_addr <= fmap_addr + FA_W'(1);
            w_addr    <= w_addr + WA_W'(1);
          end
        end
        CMP: begin
          if (better) begin
            best     <= acc;
            best_idx <= b_addr;
          end
          if (b_addr == LAST_C) begin
            // results are loaded alongside done so they are valid while done is high
            class_idx <= better ? b_addr : best_idx;
            max_score <= better ? acc : best;
            done      <= 1'b1;
            busy      <= 1'b0;
            fmap_addr <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            base      <= '0;
          end else begin
            b_addr    <= b_addr + 4'd1;
            fmap_addr <= '0;
            base      <= base + STEP;
            w_addr    <= base + STEP;
          end
        end
        DONE:    done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Bench for fc_argmax: ROM models, directed and random classification runs
// checked against a plain arithmetic dot-product/arg-max reference.
module tb_fc_argmax;

  localparam int IN_LEN  = 784;
  localparam int N_CLASS = 10;
  localparam int LAT     = N_CLASS * (IN_LEN + 2) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [9:0]        fmap_addr;
  logic signed [7:0] fmap_data;
  logic [12:0]       w_addr;
  logic signed [7:0] w_data;
  logic [3:0]        b_addr;
  logic signed [7:0] b_data;
  logic              busy, done;
  logic [3:0]        class_idx;
  logic signed [24:0] max_score;

  logic signed [7:0] fm [IN_LEN];
  logic signed [7:0] wt [N_CLASS*IN_LEN];
  logic signed [7:0] bs [N_CLASS];

  int total = 0;
  int bad   = 0;
  int last_idx = 0;
  int last_score = 0;
  int ref_idx, ref_score;

  fc_argmax #(.IN_LEN(IN_LEN), .N_CLASS(N_CLASS), .DW(8), .ACC_W(25), .FA_W(10), .WA_W(13)) dut (
    .clk(clk), .rst(rst), .start(start),
    .fmap_addr(fmap_addr), .fmap_data(fmap_data),
    .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data),
    .busy(busy), .done(done),
    .class_idx(class_idx), .max_score(max_score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    fmap_data <= fm[fmap_addr];
    w_data    <= wt[w_addr];
    b_data    <= bs[b_addr];
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(output int idx, output int score);
    int s;
    idx = 0;
    score = 0;
    for (int c = 0; c < N_CLASS; c++) begin
      s = int'(bs[c]);
      for (int i = 0; i < IN_LEN; i++) s += int'(fm[i]) * int'(wt[c*IN_LEN + i]);
      if (c == 0 || s > score) begin
        score = s;
        idx = c;
      end
    end
  endfunction

  task automatic fill_random();
    for (int i = 0; i < IN_LEN; i++) fm[i] = 8'($urandom);
    for (int i = 0; i < N_CLASS*IN_LEN; i++) wt[i] = 8'($urandom);
    for (int c = 0; c < N_CLASS; c++) bs[c] = 8'($urandom);
  endtask

  // Runs one classification; restart_at>=0 re-pulses start mid-run,
  // abort_at>=0 asserts reset at that cycle and returns early.
  task automatic run(input string name, input int restart_at, input int abort_at,
                     input int exp_idx, input int exp_score);
    int k = 0;
    int busy_cnt = 0;
    int lat = 0;
    int extra = 0;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (k < LAT + 500 && !seen) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        lat = k + 1;
      end else begin
        if (k == 50) begin
          check({name, "/hold_idx"}, class_idx, last_idx);
          check({name, "/hold_score"}, max_score, last_score);
        end
        if (k == abort_at) begin
          #2 rst = 1'b0;
          #1;
          check({name, "/rst_busy"}, busy, 0);
          check({name, "/rst_done"}, done, 0);
          check({name, "/rst_idx"}, class_idx, 0);
          check({name, "/rst_score"}, max_score, 0);
          check({name, "/rst_addr"}, {fmap_addr, w_addr, b_addr}, 0);
          @(negedge clk);
          rst = 1'b1;
          last_idx = 0;
          last_score = 0;
          return;
        end
        start = (k == restart_at);
        @(posedge clk);
        #1;
        k++;
      end
    end
    start = 1'b0;
    check({name, "/done_seen"}, seen, 1);
    check({name, "/latency"}, lat, LAT);
    check({name, "/busy_cycles"}, busy_cnt, LAT - 1);
    check({name, "/class_idx"}, class_idx, exp_idx);
    check({name, "/max_score"}, max_score, exp_score);
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check({name, "/single_done"}, extra, 0);
    check({name, "/idle_busy"}, busy, 0);
    last_idx = exp_idx;
    last_score = exp_score;
  endtask

  initial begin
    for (int i = 0; i < IN_LEN; i++) fm[i] = '0;
    for (int i = 0; i < N_CLASS*IN_LEN; i++) wt[i] = '0;
    for (int c = 0; c < N_CLASS; c++) bs[c] = 8'(c - 5);

    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/class_idx", class_idx, 0);
    check("reset/max_score", max_score, 0);
    check("reset/addr", {fmap_addr, w_addr, b_addr}, 0);
    @(negedge clk);
    rst = 1'b1;

    run("latency", -1, -1, 9, 4);

    for (int i = 0; i < IN_LEN; i++) fm[i] = 8'sd1;
    for (int c = 0; c < N_CLASS; c++) begin
      bs[c] = '0;
      for (int i = 0; i < IN_LEN; i++) wt[c*IN_LEN + i] = (c == 2) ? 8'sd1 : 8'sd0;
    end
    run("dot", -1, -1, 2, 784);

    for (int i = 0; i < IN_LEN; i++) fm[i] = '0;
    for (int c = 0; c < N_CLASS; c++) bs[c] = -8'sd3;
    run("tie_neg", -1, -1, 0, -3);

    for (int c = 0; c < N_CLASS; c++) bs[c] = (c == 4 || c == 7) ? 8'sd10 : 8'sd0;
    run("tie_pos", -1, -1, 4, 10);

    for (int i = 0; i < IN_LEN; i++) fm[i] = -8'sd128;
    for (int c = 0; c < N_CLASS; c++) begin
      bs[c] = '0;
      for (int i = 0; i < IN_LEN; i++) wt[c*IN_LEN + i] = (c == 6) ? -8'sd128 : 8'sd127;
    end
    run("extreme", -1, -1, 6, 12845056);

    fill_random();
    ref_model(ref_idx, ref_score);
    run("restart", 100, -1, ref_idx, ref_score);

    fill_random();
    ref_model(ref_idx, ref_score);
    run("abort", -1, 3000, 0, 0);
    run("after_rst", -1, -1, ref_idx, ref_score);

    fill_random();
    ref_model(ref_idx, ref_score);
    run("random", -1, -1, ref_idx, ref_score);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
